// File: rtl/cp0_m_stage.sv
// rtl/cp0_m_stage.sv - CP0 status/cause/EPC/PRId registers with interrupt and exception request
// Optional BadVAddr (reg 8) is enabled with `define CP0_BADVADDR_EN.
module cp0_m_stage #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_3105
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rdM,
    input  logic [31:0] WDM,
    input  logic        mtcoM,
    input  logic        eretM,
    input  logic [6:2]  ExcCodeM,
    input  logic        if_bdM,
    input  logic [31:0] PCM,
    input  logic [31:0] BadAddrM,
    input  logic [5:0]  HWInt,
    output logic [31:0] RD,
    output logic [31:0] EPC,
    output logic        Req
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic        int_req;
    logic        exc_req;

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCodeM != 5'd0) & ~exl_q;
    // Gated by reset so no request can escape while the block is held in reset.
    assign Req     = (int_req | exc_req) & reset;
    assign EPC     = epc_q;

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;
`else
    logic unused_badaddr;
    assign unused_badaddr = ^BadAddrM;
`endif

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = HWInt;
`ifdef CP0_BADVADDR_EN
        badvaddr_d = badvaddr_q;
`endif
        if (Req) begin
            // The flushed instruction's mtc0/eret never commits.
            exl_d     = 1'b1;
            bd_d      = if_bdM;
            exccode_d = int_req ? 5'd0 : ExcCodeM;
            epc_d     = (if_bdM ? PCM - 32'd4 : PCM) & 32'hFFFF_FFFC;
`ifdef CP0_BADVADDR_EN
            if (!int_req && (ExcCodeM == 5'd4 || ExcCodeM == 5'd5)) begin
                badvaddr_d = BadAddrM;
            end
`endif
        end else begin
            if (mtcoM) begin
                if (rdM == 5'd12) begin
                    im_d  = WDM[15:10];
                    exl_d = WDM[1];
                    ie_d  = WDM[0];
                end
                if (rdM == 5'd14) begin
                    epc_d = WDM & 32'hFFFF_FFFC;
                end
            end
            if (eretM) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= '0;
`endif
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= badvaddr_d;
`endif
        end
    end

    always_comb begin
        RD = '0;
        case (rdM)
`ifdef CP0_BADVADDR_EN
            5'd8:    RD = badvaddr_q;
`endif
            5'd12:   RD = {16'b0, im_q, 8'b0, exl_q, ie_q};
            5'd13:   RD = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
            5'd14:   RD = epc_q;
            5'd15:   RD = PRID_VALUE;
            default: RD = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_m_stage.sv
// tb/tb_cp0_m_stage.sv - directed and randomized checks of cp0_m_stage against a word-level model
module tb_cp0_m_stage;

    localparam logic [31:0] PRID = 32'h0000_3105;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rdM;
    logic [31:0] WDM;
    logic        mtcoM;
    logic        eretM;
    logic [6:2]  ExcCodeM;
    logic        if_bdM;
    logic [31:0] PCM;
    logic [31:0] BadAddrM;
    logic [5:0]  HWInt;
    logic [31:0] RD;
    logic [31:0] EPC;
    logic        Req;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_sr, m_cause, m_epc, m_bad;

    cp0_m_stage dut (
        .clk(clk), .reset(reset), .rdM(rdM), .WDM(WDM), .mtcoM(mtcoM), .eretM(eretM),
        .ExcCodeM(ExcCodeM), .if_bdM(if_bdM), .PCM(PCM), .BadAddrM(BadAddrM),
        .HWInt(HWInt), .RD(RD), .EPC(EPC), .Req(Req)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_exc();
        return (ExcCodeM != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] r);
        case (r)
            5'd8:    return m_bad;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_sr = 0; m_cause = 0; m_epc = 0; m_bad = 0;
    endtask

    task automatic model_step();
        logic i;
        logic e;
        i = m_int();
        e = m_exc();
        if (i || e) begin
            m_sr    = m_sr | 32'h2;
            m_cause = {if_bdM, 31'b0} | (i ? 32'h0 : {25'b0, ExcCodeM, 2'b0});
            m_epc   = (if_bdM ? PCM - 32'd4 : PCM) & ~32'h3;
`ifdef CP0_BADVADDR_EN
            if (!i && (ExcCodeM == 5'd4 || ExcCodeM == 5'd5)) m_bad = BadAddrM;
`endif
        end else begin
            if (mtcoM && rdM == 5'd12) m_sr = WDM & 32'h0000_FC03;
            if (mtcoM && rdM == 5'd14) m_epc = WDM & ~32'h3;
            if (eretM) m_sr = m_sr & ~32'h2;
        end
        m_cause = (m_cause & ~32'h0000_FC00) | {16'b0, HWInt, 10'b0};
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] wd, input logic mtc,
                         input logic eret, input logic [4:0] code, input logic bd,
                         input logic [31:0] pc, input logic [31:0] bad, input logic [5:0] hw);
        rdM = rd; WDM = wd; mtcoM = mtc; eretM = eret; ExcCodeM = code;
        if_bdM = bd; PCM = pc; BadAddrM = bad; HWInt = hw;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0]  regs [4] = '{5'd12, 5'd13, 5'd14, 5'd15};
        logic [31:0] want [4] = '{32'h0, 32'h0, 32'h0, PRID};
        reset = 1'b0;
        model_clear();
        drive(5'd12, 32'h0000_FFFF, 1'b1, 1'b0, 5'd9, 1'b1, 32'h100, 32'h0, 6'h3F);
        @(posedge clk);
        #1;
        if (RD !== 32'h0) begin $display("FAIL rst_hold_sr: got %h want %h", RD, 32'h0); n_fail++; end
        n_cmp++;
        if (Req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", Req); n_fail++; end
        n_cmp++;
        drive(5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rdM = regs[k];
            #1;
            if (RD !== want[k]) begin
                $display("FAIL reset_read_r%0d: got %h want %h", regs[k], RD, want[k]); n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_interrupt();
        drive(5'd12, 32'h0000_0401, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(5'd14, 32'hDEAD_BEE0, 1, 0, 0, 0, 32'h0000_3000, 0, 6'b000001);
        #1;
        if (Req !== 1'b1) begin $display("FAIL int_req: got %b want 1", Req); n_fail++; end
        n_cmp++;
        tick();
        rdM = 5'd12; #1;
        if (RD !== 32'h0000_0403) begin $display("FAIL int_sr: got %h want %h", RD, 32'h403); n_fail++; end
        n_cmp++;
        rdM = 5'd13; #1;
        if (RD !== 32'h0000_0400) begin $display("FAIL int_cause: got %h want %h", RD, 32'h400); n_fail++; end
        n_cmp++;
        if (EPC !== 32'h0000_3000) begin $display("FAIL int_epc: got %h want %h", EPC, 32'h3000); n_fail++; end
        n_cmp++;
        if (Req !== 1'b0) begin $display("FAIL int_exl_mask: got %b want 0", Req); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_exception_bd();
        drive(5'd0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(5'd0, 0, 0, 0, 5'd10, 1, 32'h0000_3010, 0, 0);
        #1;
        if (Req !== 1'b1) begin $display("FAIL exc_req: got %b want 1", Req); n_fail++; end
        n_cmp++;
        tick();
        rdM = 5'd14; #1;
        if (RD !== 32'h0000_300C) begin $display("FAIL exc_epc: got %h want %h", RD, 32'h300C); n_fail++; end
        n_cmp++;
        rdM = 5'd13; #1;
        if (RD !== 32'h8000_0028) begin $display("FAIL exc_cause: got %h want %h", RD, 32'h8000_0028); n_fail++; end
        n_cmp++;
        if (Req !== 1'b0) begin $display("FAIL exc_exl_mask: got %b want 0", Req); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_priority();
        drive(5'd0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(5'd0, 0, 0, 0, 5'd12, 0, 32'h0000_3020, 0, 6'b000001);
        tick();
        rdM = 5'd13; #1;
        if (RD !== 32'h0000_0400) begin $display("FAIL prio_cause: got %h want %h", RD, 32'h400); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_eret_epc();
        drive(5'd12, 32'h0000_0403, 1, 1, 0, 0, 0, 0, 0);
        tick();
        rdM = 5'd12; #1;
        if (RD !== 32'h0000_0401) begin $display("FAIL eret_sr: got %h want %h", RD, 32'h401); n_fail++; end
        n_cmp++;
        drive(5'd14, 32'h0000_3007, 1, 0, 0, 0, 0, 0, 0);
        tick();
        #1;
        if (RD !== 32'h0000_3004) begin $display("FAIL mtc0_epc: got %h want %h", RD, 32'h3004); n_fail++; end
        n_cmp++;
        if (EPC !== 32'h0000_3004) begin $display("FAIL epc_port: got %h want %h", EPC, 32'h3004); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_badvaddr();
        logic [31:0] want_bad;
`ifdef CP0_BADVADDR_EN
        want_bad = 32'h0000_0001;
`else
        want_bad = 32'h0;
`endif
        drive(5'd0, 0, 0, 0, 5'd4, 0, 32'h0000_3040, 32'h0000_0001, 0);
        tick();
        rdM = 5'd8; #1;
        if (RD !== want_bad) begin $display("FAIL badvaddr: got %h want %h", RD, want_bad); n_fail++; end
        n_cmp++;
        rdM = 5'd13; #1;
        if (RD !== 32'h0000_0010) begin $display("FAIL adel_cause: got %h want %h", RD, 32'h10); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        drive(5'd12, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        if (RD !== 32'h0000_0403) begin $display("FAIL pre_async_sr: got %h want %h", RD, 32'h403); n_fail++; end
        n_cmp++;
        #2;
        reset = 1'b0;
        #1;
        if (RD !== 32'h0) begin $display("FAIL async_exl_clear: got %h want %h", RD, 32'h0); n_fail++; end
        n_cmp++;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] pick [6] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        logic [31:0] want;
        for (int n = 0; n < 400; n++) begin
            drive(pick[$urandom_range(0, 5)], $urandom(), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                  1'($urandom), $urandom(), $urandom(), 6'($urandom & $urandom & $urandom));
            #1;
            if (Req !== (m_int() || m_exc())) begin
                $display("FAIL rand_req[%0d]: got %b want %b", n, Req, m_int() || m_exc()); n_fail++;
            end
            n_cmp++;
            want = m_rd(rdM);
            if (RD !== want) begin
                $display("FAIL rand_rd[%0d] r%0d: got %h want %h", n, rdM, RD, want); n_fail++;
            end
            n_cmp++;
            if (EPC !== m_epc) begin
                $display("FAIL rand_epc[%0d]: got %h want %h", n, EPC, m_epc); n_fail++;
            end
            n_cmp++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_priority();
        test_eret_epc();
        test_badvaddr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_m_stage.md
CP0_M_STAGE -- requirements
Module: cp0_m_stage

Interface
REQ-001 The block SHALL have parameter PRID_VALUE, default 32'h0000_3105, which is the constant value read from the PRId register.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port rdM, input, 5 bits: CP0 register number for mfc0 reads and mtc0 writes.
REQ-005 The block SHALL have port WDM, input, 32 bits: mtc0 write data (GPR[rt] of the M-stage instruction).
REQ-006 The block SHALL have port mtcoM, input, 1 bit: the M-stage instruction is mtc0.
REQ-007 The block SHALL have port eretM, input, 1 bit: the M-stage instruction is eret.
REQ-008 The block SHALL have port ExcCodeM, input, 5 bits [6:2]: pending exception code of the M-stage instruction; 0 means none.
REQ-009 The block SHALL have port if_bdM, input, 1 bit: the M-stage instruction sits in a branch delay slot.
REQ-010 The block SHALL have port PCM, input, 32 bits: PC of the M-stage instruction.
REQ-011 The block SHALL have port BadAddrM, input, 32 bits: faulting address (ALUoutM); used only under CP0_BADVADDR_EN.
REQ-012 The block SHALL have port HWInt, input, 6 bits: external interrupt lines, level-sensitive.
REQ-013 The block SHALL have port RD, output, 32 bits: combinational read data of register rdM.
REQ-014 The block SHALL have port EPC, output, 32 bits: current EPC register value, used as the eret target.
REQ-015 The block SHALL have port Req, output, 1 bit: combinational request to flush the pipeline and jump to the handler.

Function
REQ-016 SR (reg 12) SHALL hold IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-017 Cause (reg 13) SHALL hold BD[31], IP[15:10] and ExcCode[6:2]; all other bits SHALL read 0; Cause SHALL be read-only to mtc0.
REQ-018 EPC (reg 14) SHALL be 32 bits with bits [1:0] forced to 0.
REQ-019 PRId (reg 15) SHALL read PRID_VALUE and SHALL ignore writes.
REQ-020 RD SHALL return the selected register; unimplemented register numbers SHALL read 0.
REQ-021 The block SHALL compute IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
REQ-022 The block SHALL compute ExcReq = (ExcCodeM != 0) & !SR.EXL, and Req SHALL equal IntReq | ExcReq.
REQ-023 Cause.IP SHALL be loaded from HWInt on every clock edge, regardless of other activity.
REQ-024 On an edge with Req=1, the block SHALL set EXL to 1, load BD from if_bdM, and load ExcCode with 0 if IntReq is set, otherwise with ExcCodeM; an interrupt SHALL take priority over an exception.
REQ-025 On an edge with Req=1, EPC SHALL be loaded with (if_bdM ? PCM-4 : PCM), with bits [1:0] cleared.
REQ-026 On an edge with Req=1, any mtc0 or eret in the same cycle SHALL be suppressed, because the instruction is flushed.
REQ-027 On an edge with Req=0 and mtcoM=1, the block SHALL write SR (IM, EXL and IE fields only) when rdM=12, and EPC when rdM=14.
REQ-028 On an edge with Req=0 and eretM=1, the block SHALL clear EXL.
REQ-029 If mtc0 to SR and eret occur together, eret's EXL clear SHALL win.
REQ-030 The read latency SHALL be 0 cycles: a write becomes visible on RD in the cycle after the write edge.

Reset
REQ-031 While reset=0, the block SHALL hold SR, Cause, EPC and BadVAddr at 0, so that RD=0 (except for PRId) and Req=0.
REQ-032 An asynchronous reset assertion mid-exception SHALL clear EXL immediately, with no wait for a clock edge.

Configuration
REQ-033 With CP0_BADVADDR_EN defined, the block SHALL implement BadVAddr (reg 8), loaded from BadAddrM on an edge where Req=1 and ExcReq is taken with ExcCodeM equal to 4 (AdEL) or 5 (AdES); BadVAddr SHALL be read-only to mtc0.
REQ-034 Without CP0_BADVADDR_EN, reg 8 SHALL read 0, BadAddrM SHALL be ignored, and the port SHALL remain present.

Verification
REQ-035 Bench scenario: reset=0, then 1; read regs 12, 13, 14 and 15 -> 0, 0, 0 and 32'h0000_3105 respectively.
REQ-036 Bench scenario: mtc0 SR=32'h0000_0401, then HWInt=6'b000001 -> Req=1 in the same cycle; after the edge, EXL=1, Cause.ExcCode=0, Cause.IP=1, EPC=PCM.
REQ-037 Bench scenario: ExcCodeM=5'd10 with if_bdM=1 and PCM=32'h0000_3010 -> after the edge, EPC=32'h0000_300C, BD=1, ExcCode=10; Req stays 0 while EXL=1.
REQ-038 Bench scenario: ExcCodeM=12 and an enabled interrupt in the same cycle -> ExcCode=0 (the interrupt wins).
REQ-039 Bench scenario: eret with EXL=1 -> EXL=0 after the edge; mtc0 EPC=32'h0000_3007 -> EPC reads 32'h0000_3004.
REQ-040 Bench scenario: with CP0_BADVADDR_EN defined, ExcCodeM=4 and BadAddrM=32'h0000_0001 -> reg 8 reads 32'h0000_0001; without the macro, reg 8 reads 0.
